// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : voice_alloc
// Description : Polyphonic voice allocator. Accepts note-on/note-off events,
//               scans the voice bank one voice per cycle, then assigns,
//               releases, retriggers or steals (round-robin) a voice. It
//               drives each voice's envelope gate and oscillator key.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_alloc #(
    parameter int n_voice  = 4,
    parameter int nbit_key = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [nbit_key-1:0]          ev_key,
    input  logic [n_voice-1:0]           voice_busy,
    output logic [n_voice-1:0]           gate,
    output logic [n_voice*nbit_key-1:0]  voice_key,
    output logic                         steal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_APPLY = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [3:0] c_last = 4'(n_voice - 1);

    state_t                r_state;
    state_t                w_state_next;

    logic [3:0]            r_idx;
    logic [3:0]            r_tgt;
    logic [3:0]            r_rr;
    logic [3:0]            r_match_idx;
    logic [3:0]            r_idle_idx;
    logic [3:0]            r_rel_idx;
    logic                  r_has_match;
    logic                  r_has_idle;
    logic                  r_has_rel;
    logic                  r_ev_on;
    logic [nbit_key-1:0]   r_ev_key;
    logic                  r_gap_cnt;
    logic                  r_steal;
    logic [n_voice-1:0]    r_gate;
    logic [nbit_key-1:0]   r_key [n_voice];

    logic                  w_cur_gate;
    logic                  w_cur_busy;
    logic [nbit_key-1:0]   w_cur_key;
    logic                  w_is_match;
    logic                  w_is_idle;
    logic                  w_is_rel;

    logic [3:0]            w_sel;
    logic                  w_set;
    logic                  w_clr;
    logic                  w_wr_key;
    logic                  w_steal;

    // Select the gate, busy flag and key of the voice visited this scan cycle
    always_comb begin
        w_cur_gate = 1'b0;
        w_cur_busy = 1'b0;
        w_cur_key  = '0;
        for (int i = 0; i < n_voice; i++) begin
            if (4'(i) == r_idx) begin
                w_cur_gate = r_gate[i];
                w_cur_busy = voice_busy[i];
                w_cur_key  = r_key[i];
            end
        end
    end

    assign w_is_match = w_cur_gate && (w_cur_key == r_ev_key);
    assign w_is_idle  = !w_cur_gate && !w_cur_busy;
    assign w_is_rel   = !w_cur_gate &&  w_cur_busy;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the single gate/key action taken for the current event
    always_comb begin
        w_state_next = r_state;
        w_sel        = '0;
        w_set        = 1'b0;
        w_clr        = 1'b0;
        w_wr_key     = 1'b0;
        w_steal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ev_valid) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == c_last) begin
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_state_next = S_IDLE;
                if (r_ev_on) begin
                    if (r_has_match) begin
                        // Retrigger: drop the gate so the envelope restarts
                        w_sel        = r_match_idx;
                        w_clr        = 1'b1;
                        w_state_next = S_GAP;
                    end else if (r_has_idle) begin
                        w_sel    = r_idle_idx;
                        w_set    = 1'b1;
                        w_wr_key = 1'b1;
                    end else if (r_has_rel) begin
                        w_sel    = r_rel_idx;
                        w_set    = 1'b1;
                        w_wr_key = 1'b1;
                    end else begin
                        w_sel        = r_rr;
                        w_clr        = 1'b1;
                        w_wr_key     = 1'b1;
                        w_steal      = 1'b1;
                        w_state_next = S_GAP;
                    end
                end else if (r_has_match) begin
                    w_sel = r_match_idx;
                    w_clr = 1'b1;
                end
            end
            S_GAP: begin
                w_sel = r_tgt;
                if (r_gap_cnt) begin
                    w_set        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Event capture, scan classification, round-robin pointer and gap timing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx       <= '0;
            r_tgt       <= '0;
            r_rr        <= '0;
            r_match_idx <= '0;
            r_idle_idx  <= '0;
            r_rel_idx   <= '0;
            r_has_match <= 1'b0;
            r_has_idle  <= 1'b0;
            r_has_rel   <= 1'b0;
            r_ev_on     <= 1'b0;
            r_ev_key    <= '0;
            r_gap_cnt   <= 1'b0;
            r_steal     <= 1'b0;
        end else begin
            r_steal <= w_steal;
            case (r_state)
                S_IDLE: begin
                    if (ev_valid) begin
                        r_ev_on     <= ev_on;
                        r_ev_key    <= ev_key;
                        r_idx       <= '0;
                        r_has_match <= 1'b0;
                        r_has_idle  <= 1'b0;
                        r_has_rel   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Keep only the lowest index in each class
                    if (w_is_match && !r_has_match) begin
                        r_has_match <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                    if (w_is_idle && !r_has_idle) begin
                        r_has_idle <= 1'b1;
                        r_idle_idx <= r_idx;
                    end
                    if (w_is_rel && !r_has_rel) begin
                        r_has_rel <= 1'b1;
                        r_rel_idx <= r_idx;
                    end
                    if (r_idx != c_last) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_APPLY: begin
                    r_tgt     <= w_sel;
                    r_gap_cnt <= 1'b0;
                    if (w_steal) begin
                        r_rr <= (r_rr == c_last) ? 4'd0 : r_rr + 4'd1;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= 1'b1;
                end
                default: begin
                    r_gap_cnt <= 1'b0;
                end
            endcase
        end
    end

    // Per-voice gate and key registers; only the selected voice can change
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gate <= '0;
            for (int i = 0; i < n_voice; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            for (int i = 0; i < n_voice; i++) begin
                if (4'(i) == w_sel) begin
                    if (w_set) begin
                        r_gate[i] <= 1'b1;
                    end else if (w_clr) begin
                        r_gate[i] <= 1'b0;
                    end
                    if (w_wr_key) begin
                        r_key[i] <= r_ev_key;
                    end
                end
            end
        end
    end

    assign ev_ready = (r_state == S_IDLE);
    assign steal    = r_steal;
    assign gate     = r_gate;

    generate
        for (genvar gi = 0; gi < n_voice; gi++) begin : g_key
            assign voice_key[gi*nbit_key +: nbit_key] = r_key[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_alloc
// Description : Self-checking bench for voice_alloc. Directed scenarios plus
//               random events compared against a behavioural voice model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_alloc;

    localparam int NV = 4;
    localparam int NK = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NK-1:0]     ev_key;
    logic [NV-1:0]     voice_busy;
    logic [NV-1:0]     gate;
    logic [NV*NK-1:0]  voice_key;
    logic              steal;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the voice bank
    bit m_gate [NV];
    int m_key  [NV];
    int m_rr;

    voice_alloc #(.n_voice(NV), .nbit_key(NK)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_key     (ev_key),
        .voice_busy (voice_busy),
        .gate       (gate),
        .voice_key  (voice_key),
        .steal      (steal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_gate_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_gate[i];
        return v;
    endfunction

    function automatic logic [31:0] m_key_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NV; i++) v[i*NK +: NK] = NK'(m_key[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_key[i]  = 0;
        end
        m_rr = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        model_clear();
        rstn = 1'b1;
        tick();
    endtask

    // Issue one event and check every cycle until the allocator is ready again.
    // With abort set, reset is asserted in the first gap cycle of a steal/retrigger.
    task automatic send(input bit on, input int key, input logic [NV-1:0] busy, input bit abort);
        int  t;
        int  match;
        int  idl;
        int  rel;
        int  tgt;
        bit  gap;
        bit  stl;
        t = 0;
        while (!ev_ready && t < 20) begin
            tick();
            t++;
        end
        if (!ev_ready) check("ready_timeout", 32'(ev_ready), 32'd1);
        ev_valid   = 1'b1;
        ev_on      = on;
        ev_key     = NK'(key);
        voice_busy = busy;
        tick();
        // Held inputs after acceptance must be ignored
        ev_valid = 1'b0;
        ev_on    = 1'($urandom);
        ev_key   = NK'($urandom);

        match = -1; idl = -1; rel = -1;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m_gate[i] && m_key[i] == key) match = i;
            if (!m_gate[i] && !busy[i])      idl   = i;
            if (!m_gate[i] &&  busy[i])      rel   = i;
        end
        tgt = -1; gap = 1'b0; stl = 1'b0;
        if (on) begin
            if (match >= 0) begin
                tgt = match; gap = 1'b1;
            end else if (idl >= 0 || rel >= 0) begin
                tgt = (idl >= 0) ? idl : rel;
                m_gate[tgt] = 1'b1;
                m_key[tgt]  = key;
            end else begin
                tgt = m_rr; gap = 1'b1; stl = 1'b1;
                m_key[tgt] = key;
                m_rr = (m_rr + 1) % NV;
            end
            if (gap) m_gate[tgt] = 1'b0;
        end else if (match >= 0) begin
            m_gate[match] = 1'b0;
        end

        check("ready_e0", 32'(ev_ready), 32'd0);
        for (int e = 1; e <= NV; e++) begin
            tick();
            check("ready_scan", 32'(ev_ready), 32'd0);
        end
        tick();
        check("gate_apply", 32'(gate), m_gate_vec());
        check("key_apply", 32'(voice_key), m_key_vec());
        check("steal_apply", 32'(steal), 32'(stl));
        check("ready_apply", 32'(ev_ready), 32'(!gap));
        if (gap) begin
            if (abort) begin
                #2;
                rstn = 1'b0;
                #1;
                model_clear();
                check("gate_arst", 32'(gate), 32'd0);
                check("key_arst", 32'(voice_key), 32'd0);
                check("ready_arst", 32'(ev_ready), 32'd1);
                check("steal_arst", 32'(steal), 32'd0);
                tick();
                rstn = 1'b1;
                tick();
            end else begin
                tick();
                check("gate_gap", 32'(gate), m_gate_vec());
                check("steal_gap", 32'(steal), 32'd0);
                check("ready_gap", 32'(ev_ready), 32'd0);
                m_gate[tgt] = 1'b1;
                tick();
                check("gate_regate", 32'(gate), m_gate_vec());
                check("key_regate", 32'(voice_key), m_key_vec());
                check("ready_regate", 32'(ev_ready), 32'd1);
            end
        end
    endtask

    initial begin
        logic [NV*NK-1:0] kv;
        rstn       = 1'b0;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_key     = '0;
        voice_busy = '0;
        model_clear();
        #12;
        check("rst_ready", 32'(ev_ready), 32'd1);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_key", 32'(voice_key), 32'd0);
        check("rst_steal", 32'(steal), 32'd0);
        rstn = 1'b1;
        tick();

        // Simple note-on, then unmatched and matched note-off
        send(1'b1, 10, 4'b0000, 1'b0);
        check("on10_gate", 32'(gate), 32'h1);
        send(1'b0, 33, 4'b0000, 1'b0);
        send(1'b0, 10, 4'b0001, 1'b0);
        kv = voice_key;
        check("off10_key", 32'(kv[0 +: NK]), 32'd10);

        // Fill all voices, then two steals in round-robin order
        for (int k = 1; k <= 4; k++) send(1'b1, k, 4'b0000, 1'b0);
        send(1'b1, 5, 4'b1111, 1'b0);
        send(1'b1, 6, 4'b1111, 1'b0);
        kv = voice_key;
        check("steal_v1_key", 32'(kv[NK +: NK]), 32'd6);

        // Idle beats releasing, then releasing when nothing idle
        do_reset();
        send(1'b1, 20, 4'b0011, 1'b0);
        check("idle_pick", 32'(gate), 32'h4);
        send(1'b1, 21, 4'b1111, 1'b0);
        check("rel_pick", 32'(gate), 32'h5);

        // Retrigger of an already-sounding key
        do_reset();
        send(1'b1, 30, 4'b0000, 1'b0);
        send(1'b1, 7, 4'b0000, 1'b0);
        send(1'b1, 7, 4'b0000, 1'b0);

        // Reset during the gap of a steal, then normal operation and rr from 0
        for (int k = 1; k <= 4; k++) send(1'b1, 40 + k, 4'b0000, 1'b0);
        send(1'b1, 50, 4'b1111, 1'b1);
        send(1'b1, 3, 4'b0000, 1'b0);
        check("post_rst_gate", 32'(gate), 32'h1);
        for (int k = 1; k <= 3; k++) send(1'b1, 10 + k, 4'b0000, 1'b0);
        send(1'b1, 60, 4'b1111, 1'b0);

        // Random traffic over a small key range to exercise matches and steals
        for (int n = 0; n < 60; n++) begin
            send(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 NV'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator that shares a bank of `n_voice` ADSR envelope generators (one gate per voice) among note events from the key scanner. It accepts note-on/note-off events over a valid/ready handshake. It scans the voices sequentially and drives each envelope's gate input and the key index for that voice's oscillator. When every voice is in use, it steals a voice round-robin. It sits between the keyboard/event front end and the per-voice `adsr` + oscillator slices.

## Interface
Parameters:
- `n_voice`, 4: number of envelope/oscillator voices (2..16).
- `nbit_key`, 6: key index width.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_key`  in  nbit_key  key index of the event.
- `voice_busy`  in  n_voice  per-voice envelope activity (envelope `vout`).
- `gate`  out  n_voice  per-voice envelope gate (envelope `vin`).
- `voice_key`  out  n_voice*nbit_key  key of voice i in bits [i*nbit_key +: nbit_key].
- `steal`  out  1  one-cycle pulse when a voice is stolen.

## Operation
- FSM states: IDLE, SCAN, APPLY, GAP.
- IDLE:
  - `ev_ready`=1.
  - When `ev_valid & ev_ready` on an edge, register `ev_on`/`ev_key`, clear the scan index and candidate flags, and go to SCAN.
- SCAN:
  - Visit one voice per cycle, index 0..n_voice-1. The index is 4 bits and does not wrap past n_voice-1.
  - For voice i, record the lowest index per class:
    - match: `gate[i]`=1 and `voice_key[i]`==key.
    - idle: `gate[i]`=0 and `voice_busy[i]`=0.
    - releasing: `gate[i]`=0 and `voice_busy[i]`=1.
  - `voice_busy[i]` is sampled only in its own scan cycle.
  - After index n_voice-1, go to APPLY.
- APPLY, note-on, priority match > idle > releasing > steal:
  - match: clear `gate` of that voice, go to GAP (retrigger).
  - idle or releasing: set `gate`=1, write `voice_key`, go to IDLE.
  - steal:
    - The target is the voice at round-robin pointer `rr`.
    - Clear its gate, write `voice_key`, pulse `steal`.
    - `rr` increments modulo n_voice.
    - Go to GAP.
- APPLY, note-off:
  - On a match, clear `gate` of the lowest matching voice. `voice_key` is retained.
  - With no match, no output changes.
  - Go to IDLE.
- GAP:
  - Gate of the target is held low for 2 cycles. It is set to 1 on the edge leaving GAP, then go to IDLE.
  - The 2 low cycles guarantee the envelope leaves attack/decay/sustain and restarts from attack.
- At most one gate changes per event. Keys of other voices never change.

## Timing
- Reset values: `ev_ready`=1, `gate`=0, `voice_key`=0, `steal`=0, `rr`=0, state IDLE.
- Reset mid-operation discards the pending event.
- Edge numbering: E0 is the acceptance edge. Scan edges are E1..En, with n = n_voice.
- APPLY takes effect at E(n+1).
- Simple note-on/off: gate/key visible after E(n+1). `ev_ready`=1 after E(n+1), so the next event is accepted at E(n+2) at the earliest.
- Retrigger/steal:
  - Gate low after E(n+1).
  - Gate high after E(n+3).
  - `ev_ready`=1 after E(n+3).
  - `steal` is high only in the cycle after E(n+1).
- `ev_ready`=0 in SCAN, APPLY and GAP. The producer holds `ev_valid`/`ev_on`/`ev_key` until accepted. Inputs in those states are ignored.
- `voice_busy` changing mid-scan: the value sampled in that voice's scan cycle decides its class.
- `ev_ready` and `steal` are registered/decoded from state only, with no combinational path from `ev_valid`.

## Test plan
- Reset, all `voice_busy`=0, note-on key 10 → `gate`=0001, `voice_key[0]`=10 after E5 (n_voice=4). `ev_ready` low for E1..E5, high after.
- Voice0 gate=1 key 10, note-off key 33 → no output change. Then note-off key 10 → `gate[0]`=0 after E5 and `voice_key[0]` still 10.
- Voices 0..3 gated with keys 1..4, note-on key 5 → `steal` pulse, `gate[0]` low after E5, high after E7, `voice_key[0]`=5. A further note-on key 6 steals voice1.
- `gate`=0000, `voice_busy`=0011, note-on key 20 → voice2 chosen (idle beats releasing). Then with `voice_busy`=1111, note-on key 21 → voice0 chosen (releasing, no GAP, gate high after E5).
- Voice1 gated with key 7, note-on key 7 → `gate[1]` low after E5, high after E7, `steal`=0, no other voice changes.
- Assert `rstn`=0 during GAP of a steal → immediately `gate`=0, `voice_key`=0, `ev_ready`=1, `rr`=0. After release, a note-on key 3 goes to voice0 normally.
